// File: rtl/reorder_buffer_if.sv
// Rename/execute/retire bundle of the reorder buffer.
// master = rename + execution side, slave = the ROB.
interface reorder_buffer_if #(
    parameter int DEPTH  = 16,
    parameter int AREG_W = 5,
    parameter int PREG_W = 6
);
    localparam int TAG_W = $clog2(DEPTH);

    logic              flush;
    logic              alloc_valid;
    logic              alloc_has_rd;
    logic [AREG_W-1:0] alloc_rd;
    logic [PREG_W-1:0] alloc_prd_new;
    logic [PREG_W-1:0] alloc_prd_old;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              stall_out;
    logic              complete_valid;
    logic [TAG_W-1:0]  complete_tag;
    logic              commit_valid;
    logic [AREG_W-1:0] commit_rd;
    logic [PREG_W-1:0] commit_prd_new;
    logic              commit_free;
    logic [PREG_W-1:0] commit_prd_old;
    logic [TAG_W:0]    count;

    modport master (
        output flush, alloc_valid, alloc_has_rd, alloc_rd, alloc_prd_new, alloc_prd_old,
               complete_valid, complete_tag,
        input  alloc_ready, alloc_tag, stall_out, commit_valid, commit_rd, commit_prd_new,
               commit_free, commit_prd_old, count
    );

    modport slave (
        input  flush, alloc_valid, alloc_has_rd, alloc_rd, alloc_prd_new, alloc_prd_old,
               complete_valid, complete_tag,
        output alloc_ready, alloc_tag, stall_out, commit_valid, commit_rd, commit_prd_new,
               commit_free, commit_prd_old, count
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, marks done on writeback,
// retires from head and hands the superseded physical register back to rename.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int AREG_W = 5,
    parameter int PREG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    reorder_buffer_if.slave  rob
);
    localparam int TAG_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [DEPTH-1:0]  r_has_rd;
    logic [AREG_W-1:0] r_rd      [DEPTH];
    logic [PREG_W-1:0] r_prd_new [DEPTH];
    logic [PREG_W-1:0] r_prd_old [DEPTH];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;

    logic              w_alloc_ready;
    logic              w_alloc_fire;
    logic              w_commit_fire;
    logic              w_complete_fire;
    logic [TAG_W:0]    w_count_next;

    assign w_alloc_ready   = (r_count != (TAG_W+1)'(DEPTH));
    assign w_alloc_fire    = rob.alloc_valid & w_alloc_ready;
    assign w_commit_fire   = r_valid[r_head] & r_done[r_head];
    // A slot being allocated this cycle is still invalid, but exclude it explicitly for clarity.
    assign w_complete_fire = rob.complete_valid & r_valid[rob.complete_tag]
                             & ~(w_alloc_fire & (rob.complete_tag == r_tail));
    assign w_count_next    = r_count + (TAG_W+1)'(w_alloc_fire) - (TAG_W+1)'(w_commit_fire);

    assign rob.alloc_ready    = w_alloc_ready;
    assign rob.stall_out      = ~w_alloc_ready;
    assign rob.alloc_tag      = r_tail;
    assign rob.count          = r_count;
    assign rob.commit_valid   = w_commit_fire;
    assign rob.commit_free    = w_commit_fire & r_has_rd[r_head];
    assign rob.commit_rd      = w_commit_fire ? r_rd[r_head]      : '0;
    assign rob.commit_prd_new = w_commit_fire ? r_prd_new[r_head] : '0;
    assign rob.commit_prd_old = w_commit_fire ? r_prd_old[r_head] : '0;

    // Control state. Flush still lets the head commit combinationally; its state update is dropped.
    always_ff @(posedge clk) begin
        if (rst || rob.flush) begin
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_complete_fire) begin
                r_done[rob.complete_tag] <= 1'b1;
            end
            if (w_commit_fire) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + TAG_W'(1);
            end
            if (w_alloc_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + TAG_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Entry payload carries no reset; it is only observed through a valid entry.
    always_ff @(posedge clk) begin
        if (w_alloc_fire && !rob.flush && !rst) begin
            r_has_rd[r_tail]  <= rob.alloc_has_rd;
            r_rd[r_tail]      <= rob.alloc_rd;
            r_prd_new[r_tail] <= rob.alloc_prd_new;
            r_prd_old[r_tail] <= rob.alloc_prd_old;
        end
    end
endmodule
